// File: rtl/pipe_stage_buf_pkg.sv
// Shared register-file constants and the occupancy encoding for the EX/MEM valid/ready buffer.
package pipe_stage_buf_pkg;

    localparam int unsigned RegAddrBus = 5;
    localparam int unsigned RegDataBus = 32;

    localparam int unsigned             NOPRegAddr   = 0;
    localparam logic [RegDataBus-1:0]   ZeroWord     = '0;
    localparam logic                    WriteDisable = 1'b0;
    localparam logic                    RstEnable    = 1'b1;

    // Occupancy doubles as the count output encoding.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/pipe_entry_reg.sv
// One valid+payload slot; clear and reset park the payload at the bubble values.
module pipe_entry_reg
    import pipe_stage_buf_pkg::*;
#(
    parameter int unsigned       DATA_W   = RegDataBus,
    parameter int unsigned       ADDR_W   = RegAddrBus,
    parameter logic [ADDR_W-1:0] NOP_ADDR = ADDR_W'(NOPRegAddr)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_enable,
    input  logic [DATA_W-1:0] d_data,
    output logic              valid,
    output logic [ADDR_W-1:0] addr,
    output logic              enable,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clk) begin
        if (rst == RstEnable || clear) begin
            valid  <= 1'b0;
            addr   <= NOP_ADDR;
            enable <= WriteDisable;
            data   <= DATA_W'(ZeroWord);
        end else if (load) begin
            valid  <= 1'b1;
            addr   <= d_addr;
            enable <= d_enable;
            data   <= d_data;
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Two-entry skid buffer between EX and MEM; outputs come straight from the main slot,
// in_ready depends only on registered state.
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int unsigned       DATA_W   = RegDataBus,
    parameter int unsigned       ADDR_W   = RegAddrBus,
    parameter logic [ADDR_W-1:0] NOP_ADDR = ADDR_W'(NOPRegAddr)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_wreg_addr,
    input  logic              in_wreg_enable,
    input  logic [DATA_W-1:0] in_wdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_wreg_addr,
    output logic              out_wreg_enable,
    output logic [DATA_W-1:0] out_wdata,
    output logic [1:0]        count
);

    occ_e              occ_q;
    occ_e              occ_nxt;
    logic              in_ready_q;

    logic              main_valid;
    logic              skid_valid;
    logic [ADDR_W-1:0] skid_addr;
    logic              skid_enable;
    logic [DATA_W-1:0] skid_data;

    logic              accept;
    logic              pop;
    logic              main_load;
    logic              main_clear;
    logic              main_from_skid;
    logic              skid_load;
    logic              skid_clear;
    logic [ADDR_W-1:0] main_d_addr;
    logic              main_d_enable;
    logic [DATA_W-1:0] main_d_data;

    assign accept = in_valid && in_ready_q && !flush;
    assign pop    = main_valid && out_ready;

    assign main_d_addr   = main_from_skid ? skid_addr   : in_wreg_addr;
    assign main_d_enable = main_from_skid ? skid_enable : in_wreg_enable;
    assign main_d_data   = main_from_skid ? skid_data   : in_wdata;

    // Occupancy / in_ready register.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            occ_q      <= OCC_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            occ_q      <= occ_nxt;
            in_ready_q <= (occ_nxt != OCC_FULL);
        end
    end

    // Slot steering; flush wins over accept and pop.
    always_comb begin
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        occ_nxt        = occ_q;
        if (flush) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
            occ_nxt    = OCC_EMPTY;
        end else if (!main_valid) begin
            if (accept) begin
                main_load = 1'b1;
                occ_nxt   = OCC_ONE;
            end
        end else if (pop) begin
            if (skid_valid) begin
                main_load      = 1'b1;
                main_from_skid = 1'b1;
                skid_clear     = 1'b1;
                occ_nxt        = OCC_ONE;
            end else if (accept) begin
                main_load = 1'b1;
                occ_nxt   = OCC_ONE;
            end else begin
                main_clear = 1'b1;
                occ_nxt    = OCC_EMPTY;
            end
        end else if (accept) begin
            skid_load = 1'b1;
            occ_nxt   = OCC_FULL;
        end
    end

    pipe_entry_reg #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NOP_ADDR (NOP_ADDR)
    ) u_main (
        .clk      (clk),
        .rst      (rst),
        .clear    (main_clear),
        .load     (main_load),
        .d_addr   (main_d_addr),
        .d_enable (main_d_enable),
        .d_data   (main_d_data),
        .valid    (main_valid),
        .addr     (out_wreg_addr),
        .enable   (out_wreg_enable),
        .data     (out_wdata)
    );

    pipe_entry_reg #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NOP_ADDR (NOP_ADDR)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .clear    (skid_clear),
        .load     (skid_load),
        .d_addr   (in_wreg_addr),
        .d_enable (in_wreg_enable),
        .d_data   (in_wdata),
        .valid    (skid_valid),
        .addr     (skid_addr),
        .enable   (skid_enable),
        .data     (skid_data)
    );

    assign out_valid = main_valid;
    assign in_ready  = in_ready_q;
    assign count     = 2'(occ_q);

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed checks of the EX/MEM skid buffer followed by a queue-model random run.
module tb_pipe_stage_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_wreg_addr;
    logic        in_wreg_enable;
    logic [31:0] in_wdata;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_wreg_addr;
    logic        out_wreg_enable;
    logic [31:0] out_wdata;
    logic [1:0]  count;

    int checks = 0;
    int errors = 0;

    logic [37:0] q[$];

    always #5 clk = ~clk;

    pipe_stage_buf dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_wreg_addr    (in_wreg_addr),
        .in_wreg_enable  (in_wreg_enable),
        .in_wdata        (in_wdata),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_wreg_addr   (out_wreg_addr),
        .out_wreg_enable (out_wreg_enable),
        .out_wdata       (out_wdata),
        .count           (count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic [4:0] a, input logic en);
        in_valid       = 1'b1;
        in_wdata       = d;
        in_wreg_addr   = a;
        in_wreg_enable = en;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] d, input logic [1:0] c);
        chk({tag, "_valid"}, 64'(out_valid), 64'(1));
        chk({tag, "_data"},  64'(out_wdata), 64'(d));
        chk({tag, "_count"}, 64'(count),     64'(c));
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_valid"}, 64'(out_valid),       64'(0));
        chk({tag, "_count"}, 64'(count),           64'(0));
        chk({tag, "_addr"},  64'(out_wreg_addr),   64'(0));
        chk({tag, "_en"},    64'(out_wreg_enable), 64'(0));
        chk({tag, "_data"},  64'(out_wdata),       64'(0));
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_wreg_addr = 5'd0; in_wreg_enable = 1'b0; in_wdata = 32'd0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk_bubble("reset");
        chk("reset_in_ready", 64'(in_ready), 64'(1));

        // Streaming: one per cycle, latency one, count stays 1.
        out_ready = 1'b1;
        push(32'h11, 5'd1, 1'b1); tick(); chk_head("s11", 32'h11, 2'd1);
        chk("s11_addr", 64'(out_wreg_addr), 64'(1));
        push(32'h22, 5'd2, 1'b1); tick(); chk_head("s22", 32'h22, 2'd1);
        push(32'h33, 5'd3, 1'b1); tick(); chk_head("s33", 32'h33, 2'd1);
        push(32'h44, 5'd4, 1'b1); tick(); chk_head("s44", 32'h44, 2'd1);
        chk("s44_in_ready", 64'(in_ready), 64'(1));
        in_valid = 1'b0; tick(); chk_bubble("s_drain");

        // Backpressure: skid fills, third entry held off, then ordered drain.
        out_ready = 1'b0;
        push(32'hA1, 5'd5, 1'b1); tick(); chk_head("bp1", 32'hA1, 2'd1);
        push(32'hA2, 5'd7, 1'b0); tick(); chk_head("bp2", 32'hA1, 2'd2);
        chk("bp2_in_ready", 64'(in_ready), 64'(0));
        push(32'hA3, 5'd9, 1'b1); tick(); chk_head("bp3", 32'hA1, 2'd2);
        chk("bp3_in_ready", 64'(in_ready), 64'(0));
        out_ready = 1'b1;
        tick(); chk_head("bp_a2", 32'hA2, 2'd1);
        chk("bp_a2_en", 64'(out_wreg_enable), 64'(0));
        chk("bp_a2_addr", 64'(out_wreg_addr), 64'(7));
        chk("bp_a2_in_ready", 64'(in_ready), 64'(1));
        tick(); chk_head("bp_a3", 32'hA3, 2'd1);
        in_valid = 1'b0; tick(); chk_bubble("bp_drain");

        // Flush while full drops both entries and the same-cycle input.
        out_ready = 1'b0;
        push(32'hB1, 5'd1, 1'b1); tick();
        push(32'hB2, 5'd2, 1'b1); tick(); chk_head("fl_full", 32'hB1, 2'd2);
        flush = 1'b1; push(32'hFF, 5'd3, 1'b1); out_ready = 1'b1;
        tick(); chk_bubble("fl_after");
        chk("fl_in_ready", 64'(in_ready), 64'(1));
        flush = 1'b0; in_valid = 1'b0;
        tick(); chk_bubble("fl_nodata");

        // Reset mid-stream overrides pop.
        out_ready = 1'b0;
        push(32'hC1, 5'd1, 1'b1); tick();
        push(32'hC2, 5'd2, 1'b1); tick(); chk_head("rs_full", 32'hC2 - 32'h1, 2'd2);
        in_valid = 1'b0; rst = 1'b1; out_ready = 1'b1;
        tick(); chk_bubble("rs_after");
        rst = 1'b0;
        tick(); chk_bubble("rs_idle");
        chk("rs_in_ready", 64'(in_ready), 64'(1));

        // Random valid/ready/flush against a queue model.
        q.delete();
        for (int i = 0; i < 3000; i++) begin
            logic        acc;
            logic        pp;
            logic [37:0] item;
            chk("rnd_count", 64'(count), 64'(q.size()));
            chk("rnd_in_ready", 64'(in_ready), 64'(q.size() < 2));
            chk("rnd_out_valid", 64'(out_valid), 64'(q.size() != 0));
            if (q.size() != 0)
                chk("rnd_head", 64'({out_wreg_addr, out_wreg_enable, out_wdata}), 64'(q[0]));
            else
                chk("rnd_bubble", 64'({out_wreg_addr, out_wreg_enable, out_wdata}), 64'(0));
            in_valid       = 1'($urandom_range(0, 1));
            out_ready      = 1'($urandom_range(0, 1));
            flush          = ($urandom_range(0, 39) == 0);
            in_wreg_addr   = 5'($urandom);
            in_wreg_enable = 1'($urandom);
            in_wdata       = $urandom;
            item = {in_wreg_addr, in_wreg_enable, in_wdata};
            acc  = in_valid && (q.size() < 2) && !flush;
            pp   = (q.size() != 0) && out_ready;
            if (flush) begin
                q.delete();
            end else begin
                if (pp) void'(q.pop_front());
                if (acc) q.push_back(item);
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
